// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 request arbiter.
package l2_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } l2_arb_state_t;

    localparam logic L2_OP_READ  = 1'b0;
    localparam logic L2_OP_WRITE = 1'b1;

endpackage

// File: rtl/l2_rr_picker.sv
// Combinational round-robin picker: first set request after i_rr_last, wrapping modulo N_CORES.
module l2_rr_picker
    import l2_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_CORES-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_last,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W-1:0] w_k;

    // Walk from the farthest offset down to the nearest so the nearest set bit wins.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_k     = '0;
        for (int i = N_CORES; i >= 1; i--) begin
            w_k = IDX_W'((int'(i_rr_last) + i) % N_CORES);
            if (i_req[w_k]) begin
                o_valid = 1'b1;
                o_idx   = w_k;
            end
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing one L2 request port among N_CORES requesters.
// Optional watchdog with DRAIN recovery: define L2_ARB_TIMEOUT_EN.
module l2_request_arbiter
    import l2_arb_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_CORES-1:0]            i_core_req,
    input  logic [N_CORES*ADDR_WIDTH-1:0] i_core_addr,
    input  logic [N_CORES*DATA_WIDTH-1:0] i_core_wdata,
    input  logic [N_CORES*8-1:0]          i_core_wstrb,
    input  logic [N_CORES-1:0]            i_core_op,
    output logic [N_CORES-1:0]            o_core_gnt,
    output logic [N_CORES-1:0]            o_core_done,
    output logic [N_CORES-1:0]            o_core_err,
    output logic [DATA_WIDTH-1:0]         o_core_rdata,
    output logic                          o_l2_req,
    output logic [ADDR_WIDTH-1:0]         o_l2_addr,
    output logic [DATA_WIDTH-1:0]         o_l2_wdata,
    output logic [7:0]                    o_l2_wstrb,
    output logic                          o_l2_op,
    input  logic [DATA_WIDTH-1:0]         i_l2_rdata,
    input  logic                          i_l2_done
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    l2_arb_state_t         r_state;
    l2_arb_state_t         w_next;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      r_rr_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_wstrb;
    logic                  r_op;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_valid;
    logic [IDX_W-1:0]      w_idx;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_wstrb;
    logic [N_CORES-1:0]    w_owner_onehot;
    logic                  w_err;
    logic                  w_timeout;

    l2_rr_picker #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req     (i_core_req),
        .i_rr_last (r_rr_last),
        .o_valid   (w_valid),
        .o_idx     (w_idx)
    );

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_addr  = i_core_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = i_core_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                w_wstrb = i_core_wstrb[k*8 +: 8];
            end
        end
    end

`ifdef L2_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Done arriving on the limit cycle wins, so the timeout is only taken without it.
    assign w_timeout = (r_state == WAIT) && !i_l2_done &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_err     = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign w_err            = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (i_l2_done || w_timeout) w_next = RESP;
            RESP:    w_next = w_err ? DRAIN : IDLE;
            DRAIN:   if (i_l2_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: the wide payload registers are reset too, because every output must read 0 in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_rr_last <= IDX_W'(N_CORES - 1);
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_op      <= L2_OP_READ;
            r_rdata   <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            r_state <= w_next;
            if (r_state == IDLE && w_valid) begin
                r_owner   <= w_idx;
                r_rr_last <= w_idx;
                r_addr    <= w_addr;
                r_wdata   <= w_wdata;
                r_wstrb   <= w_wstrb;
                r_op      <= i_core_op[w_idx] ? L2_OP_WRITE : L2_OP_READ;
            end
            if (r_state == WAIT && i_l2_done) begin
                r_rdata <= i_l2_rdata;
            end
        end
    end

    assign w_owner_onehot = N_CORES'(1) << r_owner;

    assign o_core_gnt   = (r_state == ISSUE) ? w_owner_onehot : '0;
    assign o_core_done  = (r_state == RESP) ? w_owner_onehot : '0;
    assign o_core_err   = (r_state == RESP && w_err) ? w_owner_onehot : '0;
    assign o_core_rdata = (r_state == RESP && !w_err) ? r_rdata : '0;
    assign o_l2_req     = (r_state == ISSUE);
    assign o_l2_addr    = r_addr;
    assign o_l2_wdata   = r_wdata;
    assign o_l2_wstrb   = r_wstrb;
    assign o_l2_op      = r_op;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: transaction-level model plus directed literal checks.
module tb_l2_request_arbiter;

    localparam int N      = 4;
    localparam int AW     = 32;
    localparam int DW     = 256;
    localparam int TO     = 16;
    localparam int L2_LAT = 3;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      core_req   = '0;
    logic [N*AW-1:0]   core_addr  = '0;
    logic [N*DW-1:0]   core_wdata = '0;
    logic [N*8-1:0]    core_wstrb = '0;
    logic [N-1:0]      core_op    = '0;
    logic [N-1:0]      core_gnt, core_done, core_err;
    logic [DW-1:0]     core_rdata;
    logic              l2_req, l2_op;
    logic [AW-1:0]     l2_addr;
    logic [DW-1:0]     l2_wdata;
    logic [7:0]        l2_wstrb;
    logic [DW-1:0]     l2_rdata = '0;
    logic              l2_done  = 1'b0;

    l2_request_arbiter #(
        .N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_core_req(core_req), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .i_core_wstrb(core_wstrb), .i_core_op(core_op),
        .o_core_gnt(core_gnt), .o_core_done(core_done), .o_core_err(core_err),
        .o_core_rdata(core_rdata),
        .o_l2_req(l2_req), .o_l2_addr(l2_addr), .o_l2_wdata(l2_wdata),
        .o_l2_wstrb(l2_wstrb), .o_l2_op(l2_op),
        .i_l2_rdata(l2_rdata), .i_l2_done(l2_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] l2_data(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_C3C3}};
    endfunction

    // Stimulus configuration, written only by the main sequence.
    int            target[N];
    logic [AW-1:0] cfg_addr[N];
    logic [DW-1:0] cfg_wdata[N];
    logic [7:0]    cfg_wstrb[N];
    logic          cfg_op[N];
    bit            l2_mute = 1'b0;
    int            late_at = -1;

    // Observations, written only by the compare process.
    logic [N-1:0]  last_gnt = '0;
    bit            last_l2_req = 1'b0;
    logic [AW-1:0] last_l2_addr = '0;
    bit            prev_req = 1'b0;
    int            l2_req_cnt = 0;
    int            gnt_log[$];
    int            gnt_p[N], gnt_cnt[N], done_p[N], done_cnt[N];
    logic [DW-1:0] done_rdata[N];
    bit            done_err[N];
    logic [AW-1:0] iss_addr;
    logic [DW-1:0] iss_wdata;
    logic [7:0]    iss_wstrb;
    logic          iss_op;

    // Model state, written only by the model process.
    int            p = 0;
    bit            m_busy = 1'b0, m_err = 1'b0, m_drain = 1'b0;
    int            m_iss = 0, m_rsp = -1, m_owner = 0, m_rr = N - 1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic [7:0]    m_wstrb = '0;
    logic          m_op = 1'b0;

    // Requesters: hold request until granted, drop it the next cycle, re-raise while work remains.
    int granted[N];
    int rise_p[N];
    always @(posedge clk) begin : drv
        bit nxt;
        #1;
        for (int k = 0; k < N; k++) begin
            if (last_gnt[k]) granted[k]++;
            nxt = !last_gnt[k] && (granted[k] < target[k]);
            if (nxt && !core_req[k]) rise_p[k] = p;
            core_req[k]              = nxt;
            core_addr[k*AW +: AW]    = cfg_addr[k];
            core_wdata[k*DW +: DW]   = cfg_wdata[k];
            core_wstrb[k*8 +: 8]     = cfg_wstrb[k];
            core_op[k]               = cfg_op[k];
        end
    end

    // L2: done L2_LAT cycles after the request pulse, unless muted; late_at forces a stray done.
    always @(posedge clk) begin : l2m
        int cnt;
        logic [DW-1:0] pend;
        #1;
        l2_done = 1'b0;
        if (!rst_n) begin
            cnt = 0;
        end else if (last_l2_req) begin
            cnt  = L2_LAT - 1;
            pend = l2_data(last_l2_addr);
        end else if (cnt > 0) begin
            cnt--;
            l2_done = (cnt == 0) && !l2_mute;
        end
        if (p == late_at) l2_done = 1'b1;
        l2_rdata = l2_done ? pend : ~pend;
    end

    // Transaction model: which period is ISSUE, which is RESP, and what the owner/payload must be.
    always @(posedge clk or negedge rst_n) begin : mdl
        int c;
        if (!rst_n) begin
            m_busy = 1'b0; m_rr = N - 1; m_rsp = -1; m_drain = 1'b0; m_err = 1'b0;
        end else begin
            p++;
            if (!m_busy) begin
                if (core_req != '0) begin
                    c = (m_rr + 1) % N;
                    while (!core_req[c]) c = (c + 1) % N;
                    m_owner = c; m_rr = c; m_busy = 1'b1; m_iss = p; m_rsp = -1;
                    m_err = 1'b0; m_drain = 1'b0;
                    m_addr  = core_addr[c*AW +: AW];
                    m_wdata = core_wdata[c*DW +: DW];
                    m_wstrb = core_wstrb[c*8 +: 8];
                    m_op    = core_op[c];
                end
            end else if (m_rsp < 0) begin
                if (p - 1 > m_iss && l2_done) begin
                    m_rsp = p; m_rdata = l2_rdata;
                end
`ifdef L2_ARB_TIMEOUT_EN
                else if (p - 1 == m_iss + TO) begin
                    m_rsp = p; m_err = 1'b1; m_rdata = '0;
                end
`endif
            end else if (p == m_rsp + 1) begin
                if (m_err) m_drain = 1'b1;
                else       m_busy  = 1'b0;
            end else if (m_drain && l2_done) begin
                m_busy = 1'b0; m_drain = 1'b0;
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin : cmp
        logic [N-1:0] eg, ed, ee;
        eg = (m_busy && p == m_iss) ? (N'(1) << m_owner) : '0;
        ed = (m_busy && p == m_rsp) ? (N'(1) << m_owner) : '0;
        ee = (m_busy && p == m_rsp && m_err) ? (N'(1) << m_owner) : '0;
        check("gnt", core_gnt, eg);
        check("l2_req", l2_req, eg != '0);
        check("done", core_done, ed);
        check("err", core_err, ee);
        check("rdata", core_rdata, (ed != '0) ? m_rdata : '0);
        if (m_busy && p >= m_iss && (m_rsp < 0 || p <= m_rsp)) begin
            check("l2_addr", l2_addr, m_addr);
            check("l2_wdata", l2_wdata, m_wdata);
            check("l2_wstrb", l2_wstrb, m_wstrb);
            check("l2_op", l2_op, m_op);
        end
        if (l2_req) begin
            check("l2_req_b2b", prev_req, 1'b0);
            l2_req_cnt++;
        end
        for (int k = 0; k < N; k++) begin
            if (core_gnt[k]) begin
                gnt_log.push_back(k);
                gnt_p[k] = p; gnt_cnt[k]++;
                iss_addr = l2_addr; iss_wdata = l2_wdata; iss_wstrb = l2_wstrb; iss_op = l2_op;
            end
            if (core_done[k]) begin
                done_cnt[k]++; done_p[k] = p;
                done_rdata[k] = core_rdata; done_err[k] = core_err[k];
            end
        end
        prev_req     = l2_req;
        last_gnt     = core_gnt;
        last_l2_req  = l2_req;
        last_l2_addr = l2_addr;
    end

    function automatic int log_at(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : -1;
    endfunction

    task automatic wait_done(input int k, input int n, input int budget);
        int b = 0;
        while (done_cnt[k] < n && b < budget) begin
            @(negedge clk); #1; b++;
        end
        check($sformatf("wait_done_c%0d", k), done_cnt[k] >= n, 1'b1);
    endtask

    task automatic wait_gnt(input int k, input int n, input int budget);
        int b = 0;
        while (gnt_cnt[k] < n && b < budget) begin
            @(negedge clk); #1; b++;
        end
        check($sformatf("wait_gnt_c%0d", k), gnt_cnt[k] >= n, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int base, n;
        for (int k = 0; k < N; k++) begin
            target[k]    = 0;
            cfg_addr[k]  = 32'h0000_0100 * (k + 1);
            cfg_wdata[k] = '0;
            cfg_wstrb[k] = 8'h00;
            cfg_op[k]    = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", core_gnt, '0);
        check("rst_done", core_done, '0);
        check("rst_err", core_err, '0);
        check("rst_rdata", core_rdata, '0);
        check("rst_l2_req", l2_req, 1'b0);
        check("rst_l2_addr", l2_addr, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four request from reset; core 0 re-requests once
        for (int k = 0; k < N; k++) target[k] = (k == 0) ? 2 : 1;
        wait_done(0, 2, 200);
        for (int k = 1; k < N; k++) wait_done(k, 1, 50);
        check("order_len", gnt_log.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("order_%0d", i), log_at(i), exp_order[i]);
        check("l2_req_count", l2_req_cnt, 5);

        // Single read: core 2 at 0x0000_1040
        repeat (2) @(negedge clk);
        cfg_addr[2] = 32'h0000_1040;
        target[2]   = 2;
        wait_done(2, 2, 100);
        check("rd_gnt_time", gnt_p[2], rise_p[2] + 1);
        check("rd_done_time", done_p[2], rise_p[2] + 5);
        check("rd_addr", iss_addr, 32'h0000_1040);
        check("rd_op", iss_op, 1'b0);
        check("rd_data", done_rdata[2], l2_data(32'h0000_1040));
        check("rd_err", done_err[2], 1'b0);

        // Write pass-through: core 1
        cfg_addr[1]  = 32'h0000_2000;
        cfg_op[1]    = 1'b1;
        cfg_wstrb[1] = 8'h0F;
        cfg_wdata[1] = {32{8'hA5}};
        target[1]    = 2;
        wait_done(1, 2, 100);
        check("wr_op", iss_op, 1'b1);
        check("wr_wstrb", iss_wstrb, 8'h0F);
        check("wr_wdata", iss_wdata, {32{8'hA5}});
        check("wr_addr", iss_addr, 32'h0000_2000);
        check("wr_err", done_err[1], 1'b0);

        // Fairness: core 3 continuous, core 0 joins during core 3's transaction
        base = gnt_log.size();
        n = gnt_cnt[3];
        target[3] += 2;
        wait_gnt(3, n + 1, 50);
        target[0] += 1;
        wait_done(3, done_cnt[3] + 2, 300);
        check("fair_0", log_at(base), 3);
        check("fair_1", log_at(base + 1), 0);
        check("fair_2", log_at(base + 2), 3);

        // Reset mid-WAIT
        l2_mute = 1'b1;
        n = gnt_cnt[2];
        target[2] += 1;
        wait_gnt(2, n + 1, 50);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", core_gnt, '0);
        check("mid_rst_done", core_done, '0);
        check("mid_rst_err", core_err, '0);
        check("mid_rst_rdata", core_rdata, '0);
        check("mid_rst_l2_req", l2_req, 1'b0);
        check("mid_rst_l2_addr", l2_addr, '0);
        check("mid_rst_l2_wdata", l2_wdata, '0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        l2_mute = 1'b0;
        base = gnt_log.size();
        target[0] += 1;
        target[3] += 1;
        wait_done(3, done_cnt[3] + 1, 200);
        check("post_rst_0", log_at(base), 0);
        check("post_rst_1", log_at(base + 1), 3);

`ifdef L2_ARB_TIMEOUT_EN
        // Timeout: L2 never answers, then a late done is drained
        repeat (2) @(negedge clk);
        l2_mute = 1'b1;
        n = done_cnt[1];
        target[1] += 1;
        wait_done(1, n + 1, 100);
        check("to_err", done_err[1], 1'b1);
        check("to_rdata", done_rdata[1], '0);
        check("to_time", done_p[1], gnt_p[1] + 17);
        l2_mute = 1'b0;
        n = gnt_cnt[2];
        target[2] += 1;
        repeat (10) @(negedge clk);
        #1;
        check("drain_hold", gnt_cnt[2], n);
        late_at = p + 2;
        wait_gnt(2, n + 1, 50);
        check("drain_release", gnt_p[2], late_at + 2);
        wait_done(2, done_cnt[2] + 1, 50);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
